rtc_time_reader: RTL and testbench
==================================

RTC_TIME_READER -- requirements
Module: rtc_time_reader

Interface
REQ-001 The block SHALL have these ports: clock input 1: system clock, all logic on rising edge.
REQ-002 The block SHALL have these ports: reset input 1: synchronous, active-high.
REQ-003 The block SHALL have these ports: start input 1: read request, rising edge sampled.
REQ-004 The block SHALL have these ports: ad_in input 8: multiplexed RTC bus, read value.
REQ-005 The block SHALL have these ports: ad_out output 8: multiplexed RTC bus, drive value.
REQ-006 The block SHALL have these ports: ad_oe output 1: bus drive enable; 1 = block drives ad_out.
REQ-007 The block SHALL have these ports: ad output 1: address strobe, active-low.
REQ-008 The block SHALL have these ports: cs output 1: chip select, active-low.
REQ-009 The block SHALL have these ports: wr output 1: write strobe, active-low.
REQ-010 The block SHALL have these ports: rd output 1: read strobe, active-low.
REQ-011 The block SHALL have these ports: seg output 8: seconds byte, BCD, as read.
REQ-012 The block SHALL have these ports: min output 8: minutes byte, BCD, as read.
REQ-013 The block SHALL have these ports: hora output 7: hour byte bits[6:0].
REQ-014 The block SHALL have these ports: ampm output 1: hour byte bit7.
REQ-015 The block SHALL have these ports: busy output 1: sequence in progress.
REQ-016 The block SHALL have these ports: done output 1: one-cycle pulse, new time valid.

Function
REQ-017 States SHALL be IDLE, FRAME and DONE; a 6-bit frame counter cnt runs 0..39 and a 2-bit frame index idx.
REQ-018 IDLE->FRAME SHALL occur when start=1 and start was 0 on the previous cycle; busy=1 from the next cycle on, with cnt=0 and idx=0.
REQ-019 Start edges during FRAME or DONE SHALL be ignored and SHALL NOT be queued.
REQ-020 The read frames SHALL be idx0 addr 8'h21 -> seg, idx1 addr 8'h22 -> min, idx2 addr 8'h23 -> hora/ampm.
REQ-021 The address phase SHALL be: cnt0 all strobes 1; cnt1 ad=0; cnt2 cs=0; cnt3 wr=0; cnt4 ad_out=addr, ad_oe=1; cnt9 wr=1; cnt10 cs=1; cnt11 ad=1; cnt13 ad_oe=0, ad_out=8'hFF.
REQ-022 The read data phase SHALL be: cnt21 cs=0; cnt22 rd=0; cnt27 ad_in captured into the frame's shadow register; cnt28 rd=1; cnt29 cs=1.
REQ-023 ad_oe SHALL be 0 for the whole read data phase; rd=0 and ad_oe=1 SHALL never occur together.
REQ-024 After cnt39 of the last frame the block SHALL go to DONE: seg/min/hora/ampm load from shadow simultaneously, done=1 for one cycle, busy=0, then IDLE.
REQ-025 Output time registers SHALL change only in DONE; partial sequences SHALL never be visible.
REQ-026 done SHALL rise 120 cycles after the start edge is sampled (160 with REQ-032).
REQ-027 In IDLE: ad=cs=wr=rd=1, ad_oe=0, ad_out=8'hFF.

Reset
REQ-028 Reset SHALL give ad=cs=wr=rd=1, ad_oe=0, ad_out=8'hFF, seg=min=8'h00, hora=7'h00, ampm=0, busy=0, done=0, state IDLE, cnt=0, idx=0, start history=0.
REQ-029 Reset mid-frame SHALL abort immediately, with no done pulse and time outputs cleared.
REQ-030 If start is held high through reset release, it SHALL NOT trigger a sequence; a new 0->1 edge SHALL be required.

Configuration
REQ-031 Macro RTC_RD_XFER_EN SHALL control a leading transfer-command frame.
REQ-032 With RTC_RD_XFER_EN defined, a command frame SHALL precede idx0: the address phase with 8'hF2, then a write data phase of cnt21 cs=0, cnt22 wr=0, cnt23 ad_out=8'hFF with ad_oe=1, cnt28 wr=1, cnt29 cs=1, cnt31 ad_oe=0.
REQ-033 Without RTC_RD_XFER_EN, only the three read frames SHALL be issued and wr SHALL be asserted only in address phases.

Verification
REQ-034 Reset, then a start pulse with the bus model returning 8'h45/8'h30/8'h92 -> seg=8'h45, min=8'h30, hora=7'h12, ampm=1; done is a single cycle at start+120.
REQ-035 The bus monitor SHALL capture addresses 8'h21, 8'h22, 8'h23 in order, sampled while wr=0, cs=0, ad=0.
REQ-036 start held high for 500 cycles -> exactly one sequence and one done.
REQ-037 Second start edge at start+50 -> ignored; the next edge after done starts a new read.
REQ-038 Reset asserted at start+60 -> all strobes 1, ad_oe=0, outputs 0, no done.
REQ-039 RTC_RD_XFER_EN defined -> the first frame drives 8'hF2 then 8'hFF; done at start+160; the read values are as in REQ-034.

Source files
------------

// File: rtl/rtc_time_reader.sv
// Reads seconds, minutes and hour from a multiplexed-bus RTC as three
// 40-cycle frames; RTC_RD_XFER_EN adds a leading transfer-command frame.
module rtc_time_reader (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] ad_in,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  output logic       ad,
  output logic       cs,
  output logic       wr,
  output logic       rd,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [6:0] hora,
  output logic       ampm,
  output logic       busy,
  output logic       done
);

`ifdef RTC_RD_XFER_EN
  localparam logic XFER_EN = 1'b1;
`else
  localparam logic XFER_EN = 1'b0;
`endif

  localparam logic [5:0] LAST_CNT = 6'd39;
  localparam logic [5:0] CAP_CNT  = 6'd27;
  localparam logic [1:0] LAST_IDX = 2'd2;

  typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

  typedef struct packed {
    logic       ad;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       oe;
    logic [7:0] out;
  } bus_t;

  localparam bus_t BUS_IDLE = '{ad: 1'b1, cs: 1'b1, wr: 1'b1, rd: 1'b1, oe: 1'b0, out: 8'hFF};

  function automatic logic in_rng(input logic [5:0] c, input logic [5:0] lo, input logic [5:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  // Bus levels for one cycle of a frame; each strobe is low over a fixed cnt window.
  function automatic bus_t frame_bus(input logic [5:0] c, input logic cmd, input logic [1:0] i);
    bus_t       b;
    logic [7:0] addr;
    b    = BUS_IDLE;
    addr = cmd ? 8'hF2 : (8'h21 + {6'd0, i});
    if (in_rng(c, 6'd1, 6'd10))  b.ad = 1'b0;
    if (in_rng(c, 6'd2, 6'd9))   b.cs = 1'b0;
    if (in_rng(c, 6'd3, 6'd8))   b.wr = 1'b0;
    if (in_rng(c, 6'd4, 6'd12)) begin
      b.oe  = 1'b1;
      b.out = addr;
    end
    if (in_rng(c, 6'd21, 6'd28)) b.cs = 1'b0;
    if (cmd) begin
      if (in_rng(c, 6'd22, 6'd27)) b.wr = 1'b0;
      if (in_rng(c, 6'd23, 6'd30)) b.oe = 1'b1;
    end else if (in_rng(c, 6'd22, 6'd27)) begin
      b.rd = 1'b0;
    end
    return b;
  endfunction

  state_t     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       cmd_q, cmd_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       start_q, start_d;
  logic       arm_q, arm_d;
  bus_t       bus_q, bus_d;
  logic [7:0] sh_seg_q, sh_seg_d;
  logic [7:0] sh_min_q, sh_min_d;
  logic [7:0] sh_hour_q, sh_hour_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] min_q, min_d;
  logic [7:0] hour_q, hour_d;
  logic       start_edge;

  // arm_q blocks a start that was already high when reset released.
  assign start_edge = start && !start_q && arm_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    cmd_d     = cmd_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    start_d   = start;
    arm_d     = arm_q | ~start;
    sh_seg_d  = sh_seg_q;
    sh_min_d  = sh_min_q;
    sh_hour_d = sh_hour_q;
    seg_d     = seg_q;
    min_d     = min_q;
    hour_d    = hour_q;
    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = FRAME;
          cnt_d   = 6'd0;
          idx_d   = 2'd0;
          cmd_d   = XFER_EN;
          busy_d  = 1'b1;
        end
      end
      FRAME: begin
        if (!cmd_q && cnt_q == CAP_CNT) begin
          case (idx_q)
            2'd0:    sh_seg_d  = ad_in;
            2'd1:    sh_min_d  = ad_in;
            default: sh_hour_d = ad_in;
          endcase
        end
        if (cnt_q == LAST_CNT) begin
          cnt_d = 6'd0;
          if (cmd_q) begin
            cmd_d = 1'b0;
          end else if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            seg_d   = sh_seg_q;
            min_d   = sh_min_q;
            hour_d  = sh_hour_q;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bus_d = (state_d == FRAME) ? frame_bus(cnt_d, cmd_d, idx_d) : BUS_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      idx_q     <= 2'd0;
      cmd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      start_q   <= 1'b0;
      arm_q     <= ~start;
      bus_q     <= BUS_IDLE;
      sh_seg_q  <= 8'h00;
      sh_min_q  <= 8'h00;
      sh_hour_q <= 8'h00;
      seg_q     <= 8'h00;
      min_q     <= 8'h00;
      hour_q    <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      cmd_q     <= cmd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      start_q   <= start_d;
      arm_q     <= arm_d;
      bus_q     <= bus_d;
      sh_seg_q  <= sh_seg_d;
      sh_min_q  <= sh_min_d;
      sh_hour_q <= sh_hour_d;
      seg_q     <= seg_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
    end
  end

  assign ad_out = bus_q.out;
  assign ad_oe  = bus_q.oe;
  assign ad     = bus_q.ad;
  assign cs     = bus_q.cs;
  assign wr     = bus_q.wr;
  assign rd     = bus_q.rd;
  assign seg    = seg_q;
  assign min    = min_q;
  assign hora   = hour_q[6:0];
  assign ampm   = hour_q[7];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_rtc_time_reader.sv
// Randomized scoreboard bench for rtc_time_reader with an RTC bus model;
// build with RTC_RD_XFER_EN defined to cover the transfer-command frame.
module tb_rtc_time_reader;

`ifdef RTC_RD_XFER_EN
  localparam bit XFER = 1'b1;
`else
  localparam bit XFER = 1'b0;
`endif
  localparam int NFR    = XFER ? 4 : 3;
  localparam int LAT    = 40 * NFR;
  localparam int EXP_CS = 16 * NFR;
  localparam int EXP_AD = 10 * NFR;
  localparam int EXP_WR = 18 + (XFER ? 12 : 0);
  localparam int EXP_RD = 18;
  localparam int EXP_OE = 27 + (XFER ? 17 : 0);

  logic       clock = 1'b0;
  logic       reset, start;
  logic [7:0] ad_in, ad_out;
  logic       ad_oe, ad, cs, wr, rd, ampm, busy, done;
  logic [7:0] seg, min;
  logic [6:0] hora;

  rtc_time_reader dut (
    .clock(clock), .reset(reset), .start(start), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ad(ad), .cs(cs), .wr(wr), .rd(rd),
    .seg(seg), .min(min), .hora(hora), .ampm(ampm), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] s;
    logic [7:0] m;
    logic [7:0] h;
    int         dcyc;
  } exp_t;

  int         checks = 0, errors = 0, cyc = 0, done_cnt = 0;
  int         model_start = -1000, model_done = -1000;
  logic       start_prev = 1'b0;
  logic [7:0] r_sec = 8'h00, r_min = 8'h00, r_hour = 8'h00;
  exp_t       sb[$];
  logic [7:0] addr_log[$], wdata_log[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rtc_read(input logic [7:0] a);
    case (a)
      8'h21:   return r_sec;
      8'h22:   return r_min;
      8'h23:   return r_hour;
      default: return 8'h5A;
    endcase
  endfunction

  function automatic logic [7:0] exp_addr(input int i);
    if (XFER) return (i == 0) ? 8'hF2 : 8'h20 + 8'(i);
    return 8'h21 + 8'(i);
  endfunction

  // RTC bus model: latches the address on ad rising, drives read data while rd and cs are low.
  logic [7:0] lat_addr = 8'h00, bus_addr = 8'h00, wlat = 8'h00;
  logic       prev_wr = 1'b1, prev_ad = 1'b1;
  always @(negedge clock) begin
    if (reset) begin
      addr_log.delete();
      wdata_log.delete();
    end
    if (!wr && !cs && !ad && ad_oe) lat_addr = ad_out;
    if (!wr && !cs && ad && ad_oe)  wlat = ad_out;
    if (!prev_wr && wr) begin
      if (!ad) addr_log.push_back(lat_addr);
      else     wdata_log.push_back(wlat);
    end
    if (!prev_ad && ad) bus_addr = lat_addr;
    prev_wr = wr;
    prev_ad = ad;
    ad_in   = (!rd && !cs) ? rtc_read(bus_addr) : 8'($urandom);
  end

  // Monitor: protocol invariants every cycle, full scoreboard check at each done.
  int         n_cs = 0, n_ad = 0, n_wr = 0, n_rd = 0, n_oe = 0;
  logic       prev_done = 1'b0;
  logic [23:0] cur_time = 24'h0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      sb.delete();
      cur_time = 24'h0;
      n_cs = 0; n_ad = 0; n_wr = 0; n_rd = 0; n_oe = 0;
      prev_done = 1'b0;
    end else begin
      if (!cs) n_cs++;
      if (!ad) n_ad++;
      if (!wr) n_wr++;
      if (!rd) n_rd++;
      if (ad_oe) n_oe++;
      chk("rd_with_oe", 32'(!rd && ad_oe), 32'(0));
      if (!ad_oe) chk("ad_out_released", 32'(ad_out), 32'(8'hFF));
      chk("busy", 32'(busy), 32'(cyc >= model_start && cyc < model_done));
      if (done) begin
        done_cnt++;
        chk("done_width", 32'(prev_done), 32'(0));
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'(0));
        end else begin
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.dcyc));
          chk("seg", 32'(seg), 32'(e.s));
          chk("min", 32'(min), 32'(e.m));
          chk("hora", 32'(hora), 32'(e.h[6:0]));
          chk("ampm", 32'(ampm), 32'(e.h[7]));
          cur_time = {e.s, e.m, e.h[6:0], e.h[7]};
        end
        chk("addr_count", 32'(addr_log.size()), 32'(NFR));
        for (int i = 0; i < addr_log.size() && i < NFR; i++)
          chk("addr", 32'(addr_log[i]), 32'(exp_addr(i)));
        chk("wdata_count", 32'(wdata_log.size()), 32'(XFER ? 1 : 0));
        for (int i = 0; i < wdata_log.size(); i++)
          chk("wdata", 32'(wdata_log[i]), 32'(8'hFF));
        chk("cs_low_cycles", 32'(n_cs), 32'(EXP_CS));
        chk("ad_low_cycles", 32'(n_ad), 32'(EXP_AD));
        chk("wr_low_cycles", 32'(n_wr), 32'(EXP_WR));
        chk("rd_low_cycles", 32'(n_rd), 32'(EXP_RD));
        chk("oe_high_cycles", 32'(n_oe), 32'(EXP_OE));
        addr_log.delete();
        wdata_log.delete();
        n_cs = 0; n_ad = 0; n_wr = 0; n_rd = 0; n_oe = 0;
      end else begin
        chk("time_hold", 32'({seg, min, hora, ampm}), 32'(cur_time));
      end
      prev_done = done;
    end
  end

  // Drive start one cycle; a sequence begins only on a sampled 0->1 while the reader is idle.
  task automatic set_start(input logic v);
    int s;
    @(posedge clock);
    #1;
    start = v;
    s = cyc + 1;
    if (v && !start_prev && s >= model_done + 2) begin
      model_start = s;
      model_done  = s + LAT;
      sb.push_back('{s: r_sec, m: r_min, h: r_hour, dcyc: s + LAT});
    end
    start_prev = v;
  endtask

  task automatic pulse(input int w);
    for (int i = 0; i < w; i++) set_start(1'b1);
    set_start(1'b0);
  endtask

  task automatic do_reset(input logic st);
    @(posedge clock);
    #1;
    reset = 1'b1;
    start = st;
    start_prev = st;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    model_start = -1000;
    model_done  = -1000;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clock);
      if (sb.size() == 0 && cyc > model_done + 1) ok = 1'b1;
    end
    chk("wait_idle_timeout", 32'(ok), 32'(1));
  endtask

  task automatic new_regs();
    r_sec  = 8'($urandom);
    r_min  = 8'($urandom);
    r_hour = 8'($urandom);
  endtask

  initial begin
    int d0, s0;
    start = 1'b0;
    reset = 1'b1;
    do_reset(1'b0);
    @(negedge clock);
    chk("rst_bus", 32'({ad, cs, wr, rd, ad_oe, ad_out}), 32'({4'hF, 1'b0, 8'hFF}));
    chk("rst_time", 32'({seg, min, hora, ampm}), 32'(0));
    chk("rst_flags", 32'({busy, done}), 32'(0));

    r_sec = 8'h45; r_min = 8'h30; r_hour = 8'h92;
    pulse(1);
    wait_idle();
    chk("basic_time", 32'({seg, min, hora, ampm}), 32'({8'h45, 8'h30, 7'h12, 1'b1}));

    d0 = done_cnt;
    new_regs();
    set_start(1'b1);
    repeat (500) set_start(1'b1);
    set_start(1'b0);
    wait_idle();
    chk("held_start_dones", 32'(done_cnt - d0), 32'(1));

    d0 = done_cnt;
    new_regs();
    set_start(1'b1);
    s0 = model_start;
    set_start(1'b0);
    while (cyc < s0 + 48) set_start(1'b0);
    pulse(2);
    wait_idle();
    pulse(1);
    wait_idle();
    chk("ignored_edge_dones", 32'(done_cnt - d0), 32'(2));

    for (int it = 0; it < 6; it++) begin
      new_regs();
      pulse($urandom_range(1, 4));
      repeat ($urandom_range(LAT - 6, LAT + 2)) set_start(1'b0);
      pulse(1);
      wait_idle();
      repeat ($urandom_range(0, 5)) set_start(1'b0);
    end

    new_regs();
    set_start(1'b1);
    s0 = model_start;
    set_start(1'b0);
    while (cyc < s0 + 59) set_start(1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("abort_bus", 32'({ad, cs, wr, rd, ad_oe, ad_out}), 32'({4'hF, 1'b0, 8'hFF}));
    chk("abort_time", 32'({seg, min, hora, ampm}), 32'(0));
    chk("abort_flags", 32'({busy, done}), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    model_start = -1000;
    model_done  = -1000;
    d0 = done_cnt;
    repeat (200) @(negedge clock);
    chk("abort_no_done", 32'(done_cnt - d0), 32'(0));

    new_regs();
    do_reset(1'b1);
    d0 = done_cnt;
    repeat (150) set_start(1'b1);
    @(negedge clock);
    chk("held_reset_busy", 32'(busy), 32'(0));
    chk("held_reset_dones", 32'(done_cnt - d0), 32'(0));
    set_start(1'b0);
    pulse(1);
    wait_idle();
    chk("after_release_dones", 32'(done_cnt - d0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule
